// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR datapath: FSM states, accumulator
// width rule and the signed saturation function.
package fir_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        MAC  = 1'b1
    } fir_dp_state_t;

    // Width of the intermediate used by fir_sat; must exceed any accumulator width.
    localparam int SAT_W = 128;

    // Accumulator width: full product plus headroom for summing maxTaps products.
    function automatic int fir_acc_w(input int dataW, input int maxTaps);
        return 2 * dataW + $clog2(maxTaps);
    endfunction

    // Clamp a wide signed value into the signed range of outW bits.
    function automatic logic signed [SAT_W-1:0] fir_sat(input logic signed [SAT_W-1:0] value,
                                                        input int outW);
        logic signed [SAT_W-1:0] maxVal;
        logic signed [SAT_W-1:0] minVal;
        maxVal = $signed((SAT_W'(1) << (outW - 1)) - SAT_W'(1));
        minVal = -maxVal - SAT_W'(1);
        if (value > maxVal) begin
            return maxVal;
        end
        if (value < minVal) begin
            return minVal;
        end
        return value;
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Single-multiplier MAC: registered accumulator with clear/accumulate/finalize
// controls; finalize adds the last product, shifts and saturates into the result.
module fir_mac_unit
    import fir_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MAX_TAPS  = 16,
    parameter int FRAC_BITS = 0
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_clear,
    input  logic                     i_accumulate,
    input  logic                     i_finalize,
    input  logic signed [DATA_W-1:0] i_coeff,
    input  logic signed [DATA_W-1:0] i_sample,
    output logic signed [DATA_W-1:0] o_result,
    output logic                     o_valid
);

    localparam int ACC_W  = fir_acc_w(DATA_W, MAX_TAPS);
    localparam int PROD_W = 2 * DATA_W;

    logic signed [PROD_W-1:0] w_coeffExt;
    logic signed [PROD_W-1:0] w_sampleExt;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prodExt;
    logic signed [ACC_W-1:0]  w_sum;
    logic signed [ACC_W-1:0]  w_shifted;
    logic signed [SAT_W-1:0]  w_wide;
    logic signed [DATA_W-1:0] w_sat;
    logic signed [ACC_W-1:0]  r_acc;

    assign w_coeffExt  = {{DATA_W{i_coeff[DATA_W-1]}}, i_coeff};
    assign w_sampleExt = {{DATA_W{i_sample[DATA_W-1]}}, i_sample};
    assign w_prod      = w_coeffExt * w_sampleExt;
    assign w_prodExt   = {{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod};
    assign w_sum       = r_acc + w_prodExt;
    assign w_shifted   = w_sum >>> FRAC_BITS;
    assign w_wide      = {{(SAT_W - ACC_W){w_shifted[ACC_W-1]}}, w_shifted};
    assign w_sat       = DATA_W'(fir_sat(w_wide, DATA_W));

    // Accumulate one tap per cycle; finalize publishes the saturated sum with a one-cycle strobe.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_acc    <= '0;
            o_result <= '0;
            o_valid  <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (i_clear) begin
                r_acc <= '0;
            end else if (i_accumulate) begin
                r_acc <= w_sum;
            end
            if (i_finalize) begin
                o_result <= w_sat;
                o_valid  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fir_mac_datapath.sv
// FIR datapath: coefficient bank, sample delay line, load counter and the
// IDLE/MAC sequencer driving a sequential single-multiplier MAC.
module fir_mac_datapath
    import fir_pkg::*;
#(
    parameter int MAX_TAPS  = 16,
    parameter int DATA_W    = 32,
    parameter int FRAC_BITS = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [31:0]       tap_count,
    input  logic [DATA_W-1:0] coeff_data,
    input  logic              coeff_data_valid,
    input  logic [DATA_W-1:0] x_data,
    input  logic              x_data_valid,
    input  logic              compute,
    output logic              coefficient_loading_complete,
    output logic              output_data_valid,
    output logic [DATA_W-1:0] output_data,
    output logic              busy,
    output logic              sample_overrun
);

    localparam int             IDX_W = $clog2(MAX_TAPS);
    localparam logic [IDX_W:0] MAX_N = (IDX_W + 1)'(MAX_TAPS);
    localparam logic [IDX_W:0] ONE_N = (IDX_W + 1)'(1);

    fir_dp_state_t r_state;
    fir_dp_state_t w_nextState;

    logic signed [DATA_W-1:0] r_coeff [MAX_TAPS];
    logic signed [DATA_W-1:0] r_delay [MAX_TAPS];
    logic [IDX_W-1:0]         r_loadIdx;
    logic [IDX_W-1:0]         r_macIdx;
    logic [IDX_W:0]           r_numTaps;
    logic                     r_complete;
    logic                     r_overrun;

    logic [IDX_W:0]           w_reqTaps;
    logic [IDX_W:0]           w_loadTaps;
    logic                     w_busy;
    logic                     w_coeffWrite;
    logic                     w_newLoad;
    logic                     w_lastCoeff;
    logic                     w_accept;
    logic                     w_macStart;
    logic                     w_lastTap;
    logic                     w_macClear;
    logic                     w_macAcc;
    logic                     w_macFinal;
    logic                     w_idxInc;
    logic signed [DATA_W-1:0] w_result;
    logic                     w_valid;

    // Clamp the requested tap count into 1..MAX_TAPS.
    always_comb begin
        w_reqTaps = (IDX_W + 1)'(tap_count);
        if (tap_count == 32'd0) begin
            w_reqTaps = ONE_N;
        end else if (tap_count > 32'(MAX_TAPS)) begin
            w_reqTaps = MAX_N;
        end
    end

    assign w_busy       = (r_state == MAC);
    assign w_coeffWrite = coeff_data_valid && !w_busy;
    assign w_newLoad    = w_coeffWrite && r_complete;
    // The first write of a load relatches N, so its own completion test uses the new count.
    assign w_loadTaps   = (r_loadIdx == '0) ? w_reqTaps : r_numTaps;
    assign w_lastCoeff  = ({1'b0, r_loadIdx} == (w_loadTaps - ONE_N));
    // A coefficient write that restarts the load wins over a same-cycle sample, which is not taken.
    assign w_accept     = x_data_valid && r_complete && !w_busy && !w_coeffWrite;
    assign w_macStart   = w_accept && compute;
    assign w_lastTap    = ({1'b0, r_macIdx} == (r_numTaps - ONE_N));

    // Sequencer next state and MAC control strobes.
    always_comb begin
        w_nextState = r_state;
        w_macClear  = 1'b0;
        w_macAcc    = 1'b0;
        w_macFinal  = 1'b0;
        w_idxInc    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_macStart) begin
                    w_nextState = MAC;
                    w_macClear  = 1'b1;
                end
            end
            MAC: begin
                if (w_lastTap) begin
                    w_macFinal  = 1'b1;
                    w_nextState = IDLE;
                end else begin
                    w_macAcc = 1'b1;
                    w_idxInc = 1'b1;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Tap index walks the bank and delay line in lockstep during MAC.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_macIdx <= '0;
        end else if (w_macClear) begin
            r_macIdx <= '0;
        end else if (w_idxInc) begin
            r_macIdx <= r_macIdx + IDX_W'(1);
        end
    end

    // Coefficient bank writes, load counter and the completion flag.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < MAX_TAPS; i++) begin
                r_coeff[i] <= '0;
            end
            r_loadIdx  <= '0;
            r_numTaps  <= '0;
            r_complete <= 1'b0;
        end else if (w_coeffWrite) begin
            r_coeff[r_loadIdx] <= coeff_data;
            if (r_loadIdx == '0) begin
                r_numTaps <= w_reqTaps;
            end
            if (w_lastCoeff) begin
                r_complete <= 1'b1;
                r_loadIdx  <= '0;
            end else begin
                r_complete <= 1'b0;
                r_loadIdx  <= r_loadIdx + IDX_W'(1);
            end
        end
    end

    // Delay line shifts on each accepted sample and is flushed when a new load begins.
    always_ff @(posedge clk) begin
        if (!rstn || w_newLoad) begin
            for (int i = 0; i < MAX_TAPS; i++) begin
                r_delay[i] <= '0;
            end
        end else if (w_accept) begin
            r_delay[0] <= x_data;
            for (int i = 1; i < MAX_TAPS; i++) begin
                r_delay[i] <= r_delay[i-1];
            end
        end
    end

    // Sticky record of samples dropped while busy, cleared by a new load.
    always_ff @(posedge clk) begin
        if (!rstn || w_newLoad) begin
            r_overrun <= 1'b0;
        end else if (x_data_valid && w_busy) begin
            r_overrun <= 1'b1;
        end
    end

    fir_mac_unit #(
        .DATA_W    (DATA_W),
        .MAX_TAPS  (MAX_TAPS),
        .FRAC_BITS (FRAC_BITS)
    ) u_macUnit (
        .clk          (clk),
        .rstn         (rstn),
        .i_clear      (w_macClear),
        .i_accumulate (w_macAcc),
        .i_finalize   (w_macFinal),
        .i_coeff      (r_coeff[r_macIdx]),
        .i_sample     (r_delay[r_macIdx]),
        .o_result     (w_result),
        .o_valid      (w_valid)
    );

    assign coefficient_loading_complete = r_complete;
    assign output_data_valid            = w_valid;
    assign output_data                  = w_result;
    assign busy                         = w_busy;
    assign sample_overrun               = r_overrun;

endmodule

// File: tb/tb_fir_mac_datapath.sv
// Directed bench for fir_mac_datapath with hand-computed expected results.
module tb_fir_mac_datapath;

    localparam int DATA_W   = 32;
    localparam int MAX_TAPS = 16;

    logic              clk;
    logic              rstn;
    logic [31:0]       tap_count;
    logic [DATA_W-1:0] coeff_data;
    logic              coeff_data_valid;
    logic [DATA_W-1:0] x_data;
    logic              x_data_valid;
    logic              compute;
    logic              coefficient_loading_complete;
    logic              output_data_valid;
    logic [DATA_W-1:0] output_data;
    logic              busy;
    logic              sample_overrun;

    int compared   = 0;
    int mismatched = 0;

    fir_mac_datapath #(
        .MAX_TAPS  (MAX_TAPS),
        .DATA_W    (DATA_W),
        .FRAC_BITS (0)
    ) dut (
        .clk                          (clk),
        .rstn                         (rstn),
        .tap_count                    (tap_count),
        .coeff_data                   (coeff_data),
        .coeff_data_valid             (coeff_data_valid),
        .x_data                       (x_data),
        .x_data_valid                 (x_data_valid),
        .compute                      (compute),
        .coefficient_loading_complete (coefficient_loading_complete),
        .output_data_valid            (output_data_valid),
        .output_data                  (output_data),
        .busy                         (busy),
        .sample_overrun               (sample_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic writeCoeff(input logic [31:0] value);
        coeff_data       = value;
        coeff_data_valid = 1'b1;
        tick();
        coeff_data_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] sample);
        x_data       = sample;
        x_data_valid = 1'b1;
        tick();
        x_data_valid = 1'b0;
    endtask

    // startCyc is the cycle index (relative to the strobe, cycle 0) at which this is called.
    task automatic waitResult(input string tag, input logic [31:0] expected,
                              input int latency, input int startCyc);
        int cyc = startCyc;
        while (output_data_valid !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        checkOutput({tag, " latency"}, 32'(cyc), 32'(latency));
        checkOutput({tag, " data"}, output_data, expected);
        tick();
        checkOutput({tag, " pulse"}, 32'(output_data_valid), 32'd0);
        checkOutput({tag, " hold"}, output_data, expected);
    endtask

    task automatic expectQuiet(input string tag, input int cycles);
        int pulses = 0;
        repeat (cycles) begin
            tick();
            if (output_data_valid === 1'b1) pulses++;
        end
        checkOutput(tag, 32'(pulses), 32'd0);
    endtask

    initial begin
        rstn             = 1'b0;
        tap_count        = 32'd4;
        coeff_data       = '0;
        coeff_data_valid = 1'b0;
        x_data           = '0;
        x_data_valid     = 1'b0;
        compute          = 1'b1;
        tick();
        tick();
        checkOutput("reset complete", 32'(coefficient_loading_complete), 32'd0);
        checkOutput("reset valid", 32'(output_data_valid), 32'd0);
        checkOutput("reset data", output_data, 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset overrun", 32'(sample_overrun), 32'd0);
        rstn = 1'b1;
        tick();

        $display("[TB] four-tap impulse response");
        writeCoeff(32'd1);
        writeCoeff(32'd2);
        writeCoeff(32'd3);
        checkOutput("t4 complete early", 32'(coefficient_loading_complete), 32'd0);
        writeCoeff(32'd4);
        checkOutput("t4 complete", 32'(coefficient_loading_complete), 32'd1);
        applyStimulus(32'd1);
        checkOutput("t4 busy", 32'(busy), 32'd1);
        waitResult("t4 y0", 32'd1, 5, 1);
        applyStimulus(32'd0);
        waitResult("t4 y1", 32'd2, 5, 1);
        applyStimulus(32'd0);
        waitResult("t4 y2", 32'd3, 5, 1);
        applyStimulus(32'd0);
        waitResult("t4 y3", 32'd4, 5, 1);

        $display("[TB] saturation");
        tap_count = 32'd2;
        writeCoeff(32'h7FFF_FFFF);
        checkOutput("sat reload clears complete", 32'(coefficient_loading_complete), 32'd0);
        writeCoeff(32'h7FFF_FFFF);
        checkOutput("sat complete", 32'(coefficient_loading_complete), 32'd1);
        applyStimulus(32'h7FFF_FFFF);
        waitResult("sat pos y0", 32'h7FFF_FFFF, 3, 1);
        applyStimulus(32'h7FFF_FFFF);
        waitResult("sat pos y1", 32'h7FFF_FFFF, 3, 1);
        writeCoeff(32'h8000_0001);
        writeCoeff(32'h8000_0001);
        applyStimulus(32'h7FFF_FFFF);
        waitResult("sat neg y0", 32'h8000_0000, 3, 1);
        applyStimulus(32'h7FFF_FFFF);
        waitResult("sat neg y1", 32'h8000_0000, 3, 1);

        $display("[TB] tap_count boundaries");
        tap_count = 32'd0;
        writeCoeff(32'd5);
        checkOutput("n0 complete", 32'(coefficient_loading_complete), 32'd1);
        applyStimulus(32'd3);
        waitResult("n0 y", 32'd15, 2, 1);
        tap_count = 32'd40;
        for (int k = 0; k < 16; k++) begin
            writeCoeff(3 * k - 20);
            if (k == 14) begin
                checkOutput("n40 complete after 15", 32'(coefficient_loading_complete), 32'd0);
            end
        end
        checkOutput("n40 complete after 16", 32'(coefficient_loading_complete), 32'd1);
        for (int k = 0; k < 16; k++) begin
            applyStimulus((k == 0) ? 32'd1 : 32'd0);
            waitResult($sformatf("n40 y%0d", k), 3 * k - 20, 17, 1);
        end

        $display("[TB] overrun");
        tap_count = 32'd4;
        writeCoeff(32'd1);
        writeCoeff(32'd2);
        writeCoeff(32'd3);
        writeCoeff(32'd4);
        applyStimulus(32'd1);
        applyStimulus(32'd9);
        checkOutput("ovr flag", 32'(sample_overrun), 32'd1);
        waitResult("ovr y", 32'd1, 5, 2);
        expectQuiet("ovr no extra valid", 6);
        checkOutput("ovr sticky", 32'(sample_overrun), 32'd1);
        applyStimulus(32'd0);
        waitResult("ovr dropped not shifted", 32'd2, 5, 1);
        writeCoeff(32'd1);
        checkOutput("ovr cleared by load", 32'(sample_overrun), 32'd0);
        writeCoeff(32'd1);
        writeCoeff(32'd1);
        writeCoeff(32'd4);

        $display("[TB] compute gating");
        compute = 1'b0;
        applyStimulus(32'd5);
        expectQuiet("nocomp s5", 6);
        applyStimulus(32'd7);
        expectQuiet("nocomp s7", 6);
        compute = 1'b1;
        applyStimulus(32'd1);
        waitResult("comp y", 32'd13, 5, 1);

        $display("[TB] reset during MAC");
        applyStimulus(32'd2);
        checkOutput("rst busy before", 32'(busy), 32'd1);
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        checkOutput("rst complete", 32'(coefficient_loading_complete), 32'd0);
        checkOutput("rst valid", 32'(output_data_valid), 32'd0);
        checkOutput("rst data", output_data, 32'd0);
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst overrun", 32'(sample_overrun), 32'd0);
        expectQuiet("rst no valid", 8);
        writeCoeff(32'd6);
        writeCoeff(32'd7);
        writeCoeff(32'd8);
        checkOutput("rst partial load", 32'(coefficient_loading_complete), 32'd0);
        applyStimulus(32'd3);
        expectQuiet("rst sample ignored", 8);
        writeCoeff(32'd9);
        checkOutput("rst reload complete", 32'(coefficient_loading_complete), 32'd1);
        applyStimulus(32'd1);
        waitResult("rst y", 32'd6, 5, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
